// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int XLEN        = 32;

    // Wide enough for any supported ADDR_W; users slice the low bits.
    localparam logic [63:0] ALIGN_MASK = ~64'(INSTR_BYTES - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush for fetched {pc, instr} entries.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_push = push && !full;
            do_pop  = pop && !empty;
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // The issue rule upstream reserves a slot for every outstanding read.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && full));

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: drives the PC update, issues single-outstanding instruction reads
// and buffers returned instructions with their PCs for decode.
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PC,
    output logic              PCWre,
    output logic [ADDR_W-1:0] new_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir_instr,
    output logic [ADDR_W-1:0] ir_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] AMASK = ALIGN_MASK[ADDR_W-1:0];

    fetch_state_t             state_q, state_d;
    logic [ADDR_W-1:0]        req_pc_q, req_pc_d;
    logic [CW-1:0]            fifo_count;
    logic [CW:0]              occupancy;
    logic                     fifo_empty, fifo_push, fifo_pop, fifo_flush;
    logic                     rsp_keep, slot_free, issue;
    logic [ADDR_W+DATA_W-1:0] head;

    assign ir_valid = !fifo_empty;
    assign ir_pc    = head[ADDR_W+DATA_W-1:DATA_W];
    assign ir_instr = head[DATA_W-1:0];

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        PCWre      = 1'b0;
        new_addr   = PC;
        imem_req   = 1'b0;
        imem_addr  = PC & AMASK;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        rsp_keep  = (state_q == WAIT) && imem_rvalid && !redirect_valid;
        // Slot check ignores a same-cycle pop so the issue path never depends on ir_ready.
        occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, rsp_keep};
        slot_free = occupancy < (CW+1)'(DEPTH);
        issue     = !Reset && !redirect_valid && slot_free &&
                    ((state_q == IDLE) || ((state_q == WAIT) && imem_rvalid));

        if (!Reset) begin
            if (redirect_valid) begin
                PCWre      = 1'b1;
                new_addr   = redirect_addr & AMASK;
                fifo_flush = 1'b1;
                case (state_q)
                    WAIT, DROP: state_d = imem_rvalid ? IDLE : DROP;
                    default:    state_d = IDLE;
                endcase
            end else begin
                fifo_push = rsp_keep;
                fifo_pop  = !fifo_empty && ir_ready;
                if (issue) begin
                    imem_req = 1'b1;
                    PCWre    = 1'b1;
                    new_addr = PC + ADDR_W'(INSTR_BYTES);
                    req_pc_d = PC;
                    state_d  = WAIT;
                end else begin
                    case (state_q)
                        WAIT:    state_d = imem_rvalid ? IDLE : WAIT;
                        DROP:    state_d = imem_rvalid ? IDLE : DROP;
                        default: state_d = IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (Reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({req_pc_q, imem_rdata}),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule
